// File: rtl/div_unit.sv
// div_unit: signed 32/16 divider for the int16 inference datapath.
// Restoring division on magnitudes (32 iterations), then sign fix-up and
// quotient saturation to int16. Divide-by-zero bypasses the iteration loop.
module div_unit (
  input  logic        nvdla_core_clk,
  input  logic        nvdla_core_rstn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] dividend,
  input  logic [15:0] divisor,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] quotient,
  output logic [15:0] remainder,
  output logic        ovf,
  output logic        dz
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_SIGN = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Magnitude of a 32-bit two's-complement value; -2^31 maps to 0x80000000.
  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

  // Magnitude of a 16-bit two's-complement value; -32768 maps to 0x8000.
  function automatic logic [15:0] abs16(input logic [15:0] v);
    return v[15] ? (~v + 16'd1) : v;
  endfunction

  // Two's-complement negation at 16 bits.
  function automatic logic [15:0] neg16(input logic [15:0] v);
    return ~v + 16'd1;
  endfunction

  state_t      state_r;
  state_t      state_s;
  logic [4:0]  iter_r;
  logic [31:0] dvd_r;      // dividend magnitude, shifts left; ends holding the quotient
  logic [15:0] dsr_r;      // divisor magnitude
  logic [16:0] rem_r;      // partial remainder, one spare bit for the trial subtract
  logic        sign_dvd_r;
  logic        sign_dsr_r;

  logic        accept_s;
  logic        div_zero_s;
  logic [16:0] rem_shift_s;
  logic        q_bit_s;
  logic [16:0] rem_next_s;
  logic        sign_q_s;
  logic [15:0] quot_sat_s;
  logic        ovf_s;
  logic [15:0] rem_sgn_s;

  assign accept_s   = in_valid & (state_r == ST_IDLE);
  assign div_zero_s = (divisor == 16'd0);

  // State register.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (in_valid) begin
          if (div_zero_s) begin
            state_s = ST_DONE;
          end else begin
            state_s = ST_CALC;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_CALC: begin
        if (iter_r == 5'd31) begin
          state_s = ST_SIGN;
        end else begin
          state_s = ST_CALC;
        end
      end
      ST_SIGN: state_s = ST_DONE;
      ST_DONE: begin
        if (out_ready) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DONE;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // One restoring-division step: shift in the next dividend bit, trial subtract.
  always_comb begin
    rem_shift_s = {rem_r[15:0], dvd_r[31]};
    q_bit_s     = (rem_shift_s >= {1'b0, dsr_r});
    if (q_bit_s) begin
      rem_next_s = rem_shift_s - {1'b0, dsr_r};
    end else begin
      rem_next_s = rem_shift_s;
    end
  end

  // Sign fix-up and int16 saturation of the finished quotient magnitude.
  always_comb begin
    sign_q_s   = sign_dvd_r ^ sign_dsr_r;
    quot_sat_s = 16'd0;
    ovf_s      = 1'b0;
    if (sign_q_s) begin
      if (dvd_r > 32'd32768) begin
        quot_sat_s = 16'h8000;
        ovf_s      = 1'b1;
      end else begin
        quot_sat_s = neg16(dvd_r[15:0]);
        ovf_s      = 1'b0;
      end
    end else begin
      if (dvd_r > 32'd32767) begin
        quot_sat_s = 16'h7FFF;
        ovf_s      = 1'b1;
      end else begin
        quot_sat_s = dvd_r[15:0];
        ovf_s      = 1'b0;
      end
    end
    if (sign_dvd_r) begin
      rem_sgn_s = neg16(rem_r[15:0]);
    end else begin
      rem_sgn_s = rem_r[15:0];
    end
  end

  // Datapath and registered outputs, sequenced by the FSM state.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      iter_r     <= 5'd0;
      dvd_r      <= 32'd0;
      dsr_r      <= 16'd0;
      rem_r      <= 17'd0;
      sign_dvd_r <= 1'b0;
      sign_dsr_r <= 1'b0;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      quotient   <= 16'd0;
      remainder  <= 16'd0;
      ovf        <= 1'b0;
      dz         <= 1'b0;
    end else begin
      in_ready <= (state_s == ST_IDLE);
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            sign_dvd_r <= dividend[31];
            sign_dsr_r <= divisor[15];
            dvd_r      <= abs32(dividend);
            dsr_r      <= abs16(divisor);
            rem_r      <= 17'd0;
            iter_r     <= 5'd0;
            if (div_zero_s) begin
              out_valid <= 1'b1;
              dz        <= 1'b1;
              ovf       <= 1'b0;
              remainder <= 16'd0;
              quotient  <= dividend[31] ? 16'h8000 : 16'h7FFF;
            end
          end
        end
        ST_CALC: begin
          rem_r  <= rem_next_s;
          dvd_r  <= {dvd_r[30:0], q_bit_s};
          iter_r <= iter_r + 5'd1;
        end
        ST_SIGN: begin
          quotient  <= quot_sat_s;
          remainder <= rem_sgn_s;
          ovf       <= ovf_s;
          dz        <= 1'b0;
          out_valid <= 1'b1;
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        default: begin
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit.
module tb_div_unit;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] dividend;
  logic [15:0] divisor;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        ovf;
  logic        dz;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int t0    = 0;
  int lat   = 0;
  int seen  = 0;

  div_unit dut (
    .nvdla_core_clk (clk),
    .nvdla_core_rstn(rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .dividend       (dividend),
    .divisor        (divisor),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .quotient       (quotient),
    .remainder      (remainder),
    .ovf            (ovf),
    .dz             (dz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present operands for one cycle (handshake cycle T); returns in cycle T+1.
  task automatic start_op(input logic [31:0] a, input logic [15:0] b, input string tag);
    @(negedge clk);
    chk({tag, " in_ready"}, {31'd0, in_ready}, 32'd1);
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    t0 = cyc;
    @(negedge clk);
    in_valid = 1'b0;
    dividend = 32'h5A5A5A5A;
    divisor  = 16'hA5A5;
  endtask

  // Wait (bounded) for out_valid and check the latency from the handshake.
  task automatic wait_valid(input int exp_lat, input string tag);
    int n;
    n = 0;
    while (!out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    lat = cyc - t0;
    chk({tag, " latency"}, lat, exp_lat);
  endtask

  task automatic check_res(input logic [15:0] q, input logic [15:0] r,
                           input logic o, input logic z, input string tag);
    chk({tag, " quotient"}, {16'd0, quotient}, {16'd0, q});
    chk({tag, " remainder"}, {16'd0, remainder}, {16'd0, r});
    chk({tag, " ovf"}, {31'd0, ovf}, {31'd0, o});
    chk({tag, " dz"}, {31'd0, dz}, {31'd0, z});
    chk({tag, " in_ready low"}, {31'd0, in_ready}, 32'd0);
  endtask

  task automatic finish_op(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, " out_valid cleared"}, {31'd0, out_valid}, 32'd0);
    chk({tag, " in_ready back"}, {31'd0, in_ready}, 32'd1);
  endtask

  task automatic run_op(input logic [31:0] a, input logic [15:0] b, input int l,
                        input logic [15:0] q, input logic [15:0] r,
                        input logic o, input logic z, input string tag);
    start_op(a, b, tag);
    wait_valid(l, tag);
    check_res(q, r, o, z, tag);
    finish_op(tag);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = 32'd0;
    divisor   = 16'd0;
    #1;
    chk("reset out_valid", {31'd0, out_valid}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset quotient", {16'd0, quotient}, 32'd0);
    chk("reset remainder", {16'd0, remainder}, 32'd0);
    chk("reset ovf", {31'd0, ovf}, 32'd0);
    chk("reset dz", {31'd0, dz}, 32'd0);

    // Basic signed cases.
    run_op(32'd100,       16'd7,      34, 16'h000E, 16'h0002, 1'b0, 1'b0, "100/7");
    run_op(32'hFFFFFF9C,  16'd7,      34, 16'hFFF2, 16'hFFFE, 1'b0, 1'b0, "-100/7");
    run_op(32'hFFFFFF9C,  16'hFFF9,   34, 16'h000E, 16'hFFFE, 1'b0, 1'b0, "-100/-7");
    run_op(32'd1000,      16'hFFDF,   34, 16'hFFE2, 16'h000A, 1'b0, 1'b0, "1000/-33");
    run_op(32'd0,         16'd5,      34, 16'h0000, 16'h0000, 1'b0, 1'b0, "0/5");

    // Range edges.
    run_op(32'h7FFFFFFF,  16'd1,      34, 16'h7FFF, 16'h0000, 1'b1, 1'b0, "max/1");
    run_op(32'h80000000,  16'hFFFF,   34, 16'h7FFF, 16'h0000, 1'b1, 1'b0, "min/-1");
    run_op(32'hFFFF8000,  16'd1,      34, 16'h8000, 16'h0000, 1'b0, 1'b0, "-32768/1");
    run_op(32'h40000000,  16'h8000,   34, 16'h8000, 16'h0000, 1'b0, 1'b0, "2^30/-32768");
    run_op(32'd32768,     16'd1,      34, 16'h7FFF, 16'h0000, 1'b1, 1'b0, "32768/1");
    run_op(32'hFFFF7FFF,  16'd1,      34, 16'h8000, 16'h0000, 1'b1, 1'b0, "-32769/1");

    // Divide by zero.
    run_op(32'd5,         16'd0,       1, 16'h7FFF, 16'h0000, 1'b0, 1'b1, "5/0");
    run_op(32'hFFFFFFFB,  16'd0,       1, 16'h8000, 16'h0000, 1'b0, 1'b1, "-5/0");

    // Stray in_valid during CALC, then hold the result with out_ready low.
    start_op(32'd100, 16'd7, "hold");
    repeat (4) @(negedge clk);
    dividend = 32'd999;
    divisor  = 16'd3;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    wait_valid(34, "hold");
    for (int i = 0; i < 10; i++) begin
      check_res(16'h000E, 16'h0002, 1'b0, 1'b0, "hold");
      chk("hold out_valid", {31'd0, out_valid}, 32'd1);
      @(negedge clk);
    end
    finish_op("hold");

    // Reset at T+10 abandons the operation.
    start_op(32'd100, 16'd7, "rst_calc");
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_calc out_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_calc in_ready", {31'd0, in_ready}, 32'd1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) seen++;
      @(negedge clk);
    end
    chk("rst_calc no result", seen, 32'd0);

    // Reset while a result is presented drops out_valid asynchronously.
    start_op(32'd100, 16'd7, "rst_done");
    wait_valid(34, "rst_done");
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_done out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_done quotient", {16'd0, quotient}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_done in_ready", {31'd0, in_ready}, 32'd1);

    run_op(32'd100, 16'd7, 34, 16'h000E, 16'h0002, 1'b0, 1'b0, "after reset 100/7");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 Parameters: none; widths are fixed to the int16 inference datapath.
REQ-002 nvdla_core_clk  input  1  single clock; all state updates on the rising edge.
REQ-003 nvdla_core_rstn  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  operand pair presented.
REQ-005 in_ready  output  1  block can accept operands.
REQ-006 dividend  input  32  signed two's-complement dividend (int16 product domain).
REQ-007 divisor  input  16  signed two's-complement divisor.
REQ-008 out_valid  output  1  result presented.
REQ-009 out_ready  input  1  consumer accepts result.
REQ-010 quotient  output  16  signed quotient, truncated toward zero, saturated.
REQ-011 remainder  output  16  signed remainder, sign follows dividend.
REQ-012 ovf  output  1  quotient saturated due to range overflow.
REQ-013 dz  output  1  divisor was zero.

Function
REQ-014 The FSM states SHALL be IDLE, CALC, SIGN and DONE; in_ready SHALL be 1 only in IDLE.
REQ-015 An input handshake (in_valid & in_ready) in cycle T SHALL register the operand signs, the 32-bit dividend magnitude and the 16-bit divisor magnitude.
REQ-016 Magnitudes SHALL be formed by conditional two's complement; -2^31 SHALL yield magnitude 0x80000000 and -32768 SHALL yield 0x8000, with no truncation.
REQ-017 With a nonzero divisor, IDLE SHALL go to CALC.
REQ-018 CALC SHALL run unsigned restoring division, one quotient bit per cycle, MSB first, for exactly 32 cycles (T+1..T+32), using a 5-bit iteration counter.
REQ-019 The partial remainder SHALL be 17 bits wide so the trial subtraction never loses a carry.
REQ-020 After the 32nd iteration, CALC SHALL go to SIGN (cycle T+33).
REQ-021 SIGN SHALL apply sign_q = sign_dividend XOR sign_divisor to the quotient magnitude and sign_dividend to the remainder magnitude.
REQ-022 SIGN SHALL saturate the quotient:
  - positive result with magnitude > 32767 -> 0x7FFF, ovf=1;
  - negative result with magnitude > 32768 -> 0x8000, ovf=1;
  - otherwise exact, ovf=0.
REQ-023 SIGN SHALL go to DONE; out_valid SHALL be 1 from cycle T+34, giving a fixed latency of 34 cycles.
REQ-024 The remainder SHALL always fit in 16 bits, since its magnitude is below the divisor magnitude (max 32767); no saturation SHALL be applied to it.
REQ-025 Divide by zero: IDLE SHALL go directly to DONE with out_valid=1 at T+1.
  - dz=1, remainder=0, ovf=0.
  - quotient=0x7FFF when dividend >= 0, else 0x8000.
REQ-026 In DONE, quotient, remainder, ovf and dz SHALL remain stable while out_valid=1 and out_ready=0.
REQ-027 In DONE, out_ready=1 SHALL complete the transfer and the FSM SHALL return to IDLE the next cycle; in_ready=1 SHALL not coincide with out_valid=1 (no same-cycle turnaround).
REQ-028 in_valid asserted outside IDLE SHALL be ignored and SHALL not disturb the operation in progress.
REQ-029 Dividend 0 SHALL give quotient 0, remainder 0, ovf 0.

Reset
REQ-030 Asserting nvdla_core_rstn low SHALL immediately, independent of the clock, force:
  - state IDLE, iteration counter 0;
  - out_valid=0, quotient=0, remainder=0, ovf=0, dz=0;
  - in_ready=1 once reset is released.
REQ-031 A reset during CALC, SIGN or DONE SHALL abandon the operation; no result SHALL be presented after reset release.

Verification
REQ-032 100 / 7, handshake at T -> out_valid at T+34, quotient=14, remainder=2, ovf=0, dz=0.
REQ-033 -100 / 7 -> quotient=-14 (0xFFF2), remainder=-2 (0xFFFE); -100 / -7 -> quotient=14, remainder=-2.
REQ-034 Range edges:
  - 0x7FFFFFFF / 1 -> quotient=0x7FFF, ovf=1.
  - -2147483648 / -1 -> quotient=0x7FFF, ovf=1.
  - -32768 / 1 -> quotient=0x8000, ovf=0.
  - 1073741824 / -32768 -> quotient=0x8000, remainder=0, ovf=0.
REQ-035 5 / 0 -> out_valid at T+1, quotient=0x7FFF, dz=1; -5 / 0 -> quotient=0x8000, dz=1.
REQ-036 Hold out_ready=0 for 10 cycles in DONE -> outputs stable and in_ready=0; a pulsed in_valid during CALC leaves the result unchanged.
REQ-037 Pulse nvdla_core_rstn low at T+10 of an operation -> out_valid=0 immediately, in_ready=1 after release, and a following 100 / 7 completes correctly.
